// File: rtl/stream_mux_arb_pkg.sv
// stream_mux_arb_pkg
//   Shared definitions for the stream multiplexer/arbiter:
//   - arbitration mode encodings (arb_mode input values)
//   - clog2w(): ceiling log2 used to size channel-index fields
package stream_mux_arb_pkg;

  localparam logic [1:0] ARB_MANUAL = 2'b00;
  localparam logic [1:0] ARB_FIXED  = 2'b01;
  localparam logic [1:0] ARB_RR     = 2'b10;  // 2'b11 also selects round-robin

  // Ceiling log2. It returns at least 1, so a 1-bit index is always legal.
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// rr_arbiter
//   Purely combinational request -> grant logic for the stream multiplexer.
//   Ports:
//     req_i       in   NUM_CH  per-channel request (in_valid)
//     ptr_i       in   SEL_W   round-robin search start (always < NUM_CH)
//     sel_i       in   SEL_W   manual-mode channel index
//     mode_i      in   2       arbitration mode (see package)
//     grant_o     out  NUM_CH  one-hot grant, or zero
//     grant_idx_o out  SEL_W   index of the granted channel (0 when none)
//     grant_vld_o out  1       a channel is granted
module rr_arbiter
  import stream_mux_arb_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = clog2w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [1:0]        mode_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [SEL_W-1:0]  grant_idx_o,
  output logic              grant_vld_o
);

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;

    if (mode_i == ARB_MANUAL) begin
      // Comparing against every legal index means an out-of-range sel
      // simply never matches, so no grant is produced.
      for (int k = 0; k < NUM_CH; k++) begin
        if ((int'(sel_i) == k) && req_i[k]) begin
          grant_vld_o = 1'b1;
          grant_idx_o = SEL_W'(k);
        end
      end
    end else if (mode_i == ARB_FIXED) begin
      // Scan from the top down; the last hit is the lowest valid index.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (req_i[k]) begin
          grant_vld_o = 1'b1;
          grant_idx_o = SEL_W'(k);
        end
      end
    end else begin
      // Same descending trick over the rotated order ptr, ptr+1, ...
      // The last hit is the first valid channel at or after ptr.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (req_i[(int'(ptr_i) + k) % NUM_CH]) begin
          grant_vld_o = 1'b1;
          grant_idx_o = SEL_W'((int'(ptr_i) + k) % NUM_CH);
        end
      end
    end

    if (grant_vld_o) grant_o[grant_idx_o] = 1'b1;
  end

endmodule

// File: rtl/stream_mux_arb.sv
// stream_mux_arb
//   N-channel stream selector with a registered valid/ready output stage.
//   It supports manual, fixed-priority and round-robin arbitration, selected at runtime.
//   Ports:
//     clk       in   1                  clock, rising edge
//     rst_n     in   1                  asynchronous active-low reset
//     arb_mode  in   2                  00 manual, 01 fixed, 1x round-robin
//     sel       in   SEL_W              manual-mode channel
//     in_data   in   NUM_CH*DATA_WIDTH  channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//     in_valid  in   NUM_CH             per-channel request
//     in_ready  out  NUM_CH             one-hot accept (combinational from out_ready)
//     out_data  out  DATA_WIDTH         registered selected word
//     out_valid out  1                  output register holds a word
//     out_ready in   1                  consumer accepts the word
//     out_ch    out  SEL_W              source channel of out_data
module stream_mux_arb
  import stream_mux_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_CH     = 8,
  parameter int SEL_W      = clog2w(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   arb_mode,
  input  logic [SEL_W-1:0]             sel,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SEL_W-1:0]             out_ch
);

  logic [DATA_WIDTH-1:0] words [NUM_CH];
  logic [NUM_CH-1:0]     grant;
  logic [SEL_W-1:0]      grant_idx;
  logic                  grant_vld;
  logic                  load;
  logic                  xfer;

  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]      out_ch_q, out_ch_d;
  logic                  out_valid_q, out_valid_d;
  logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_words
    assign words[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req_i       (in_valid),
    .ptr_i       (rr_ptr_q),
    .sel_i       (sel),
    .mode_i      (arb_mode),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld)
  );

  // The output register may take a new word when it is empty or being drained.
  assign load     = !out_valid_q || out_ready;
  // rst_n gating keeps every accept low while the block is held in reset.
  assign in_ready = (load && rst_n) ? grant : '0;
  // The arbiter grants only requesting channels, so a grant under load is a transfer.
  assign xfer     = load && grant_vld && rst_n;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) out_valid_d = xfer;
    if (xfer) begin
      out_data_d = words[grant_idx];
      out_ch_d   = grant_idx;
      // Both 2'b10 and 2'b11 select round-robin, so only bit 1 matters.
      if (arb_mode[1]) begin
        rr_ptr_d = (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb
//   Directed bench for stream_mux_arb (DATA_WIDTH=4, NUM_CH=8).
//   A behavioural model computes the expected outputs and is compared against the DUT on every falling edge.
//   The stimulus block adds hand-computed literal checks.
module tb_stream_mux_arb;
  localparam int DW = 4;
  localparam int N  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    arb_mode;
  logic [SW-1:0] sel;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_ch;

  int checks   = 0;
  int failures = 0;

  stream_mux_arb #(.DATA_WIDTH(DW), .NUM_CH(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_mode  (arb_mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Winner by the arbitration rules: build the search order, take the first requester.
  function automatic int pick(input logic [1:0] mode, input int s, input logic [N-1:0] v, input int ptr);
    int order[$];
    int res;
    res = -1;
    if (mode == 2'b00) begin
      if (s < N) order.push_back(s);
    end else if (mode == 2'b01) begin
      for (int k = 0; k < N; k++) order.push_back(k);
    end else begin
      for (int k = 0; k < N; k++) order.push_back((ptr + k) % N);
    end
    foreach (order[j]) begin
      if (res < 0 && v[order[j]]) res = order[j];
    end
    return res;
  endfunction

  // Model state
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_ch;
  int            m_ptr;
  logic          m_load;
  int            m_g;
  logic [N-1:0]  m_rdy;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
      chk("m_rst_in_ready", 32'(in_ready), 32'd0);
      chk("m_rst_out_valid", 32'(out_valid), 32'd0);
    end else begin
      m_load = !m_valid || out_ready;
      m_g    = pick(arb_mode, int'(sel), in_valid, m_ptr);
      m_rdy  = (m_load && m_g >= 0) ? N'(1 << m_g) : '0;
      chk("m_in_ready", 32'(in_ready), 32'(m_rdy));
      chk("m_out_valid", 32'(out_valid), 32'(m_valid));
      chk("m_out_data", 32'(out_data), 32'(m_data));
      chk("m_out_ch", 32'(out_ch), 32'(m_ch));
      chk("m_rr_ptr", 32'(dut.rr_ptr_q), 32'(m_ptr));
      if (m_load) begin
        m_valid = (m_g >= 0);
        if (m_g >= 0) begin
          m_data = in_data[m_g*DW +: DW];
          m_ch   = m_g;
          if (arb_mode[1]) m_ptr = (m_g + 1) % N;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; arb_mode = 2'b00; sel = '0; in_valid = '0; out_ready = 1'b0;
    for (int k = 0; k < N; k++) in_data[k*DW +: DW] = DW'(k);
    repeat (3) tick();
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_out_ch", 32'(out_ch), 32'd0);
    rst_n = 1'b1;
    tick();

    // Round-robin, every channel requesting: channels in order, wrapping 7->0.
    arb_mode = 2'b10; in_valid = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("rr_out_valid", 32'(out_valid), 32'd1);
      chk("rr_out_ch", 32'(out_ch), 32'(i % 8));
      chk("rr_out_data", 32'(out_data), 32'(i % 8));
    end

    // Fixed priority: lowest requester (ch2) wins every time.
    arb_mode = 2'b01; in_valid = 8'b1010_0100;
    #1 chk("fixed_in_ready", 32'(in_ready), 32'h04);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fixed_out_ch", 32'(out_ch), 32'd2);
      chk("fixed_in_ready_hold", 32'(in_ready), 32'h04);
    end

    // Manual select of ch5, then with ch5 idle.
    arb_mode = 2'b00; sel = 3'd5; in_valid = 8'h20; in_data[5*DW +: DW] = 4'hA;
    #1 chk("manual_in_ready", 32'(in_ready), 32'h20);
    tick();
    chk("manual_out_data", 32'(out_data), 32'hA);
    chk("manual_out_ch", 32'(out_ch), 32'd5);
    in_valid = 8'h1F;
    #1 chk("manual_idle_in_ready", 32'(in_ready), 32'h00);
    tick();
    chk("manual_idle_out_valid", 32'(out_valid), 32'd0);

    // Backpressure: capture 4'h3, stall four cycles, then release.
    arb_mode = 2'b01; in_valid = 8'h08;
    #1 chk("bp_in_ready", 32'(in_ready), 32'h08);
    tick();
    chk("bp_capture_data", 32'(out_data), 32'h3);
    chk("bp_capture_ch", 32'(out_ch), 32'd3);
    out_ready = 1'b0; in_valid = 8'h01;
    #1 chk("bp_stall_in_ready", 32'(in_ready), 32'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_data", 32'(out_data), 32'h3);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_in_ready", 32'(in_ready), 32'h00);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready", 32'(in_ready), 32'h01);
    tick();
    chk("bp_next_data", 32'(out_data), 32'h0);
    chk("bp_next_ch", 32'(out_ch), 32'd0);

    // Mode switch RR -> fixed while the output is stalled (pointer is 1 here).
    arb_mode = 2'b10; in_valid = 8'hFF;
    tick();
    chk("sw_rr_out_ch", 32'(out_ch), 32'd1);
    out_ready = 1'b0; arb_mode = 2'b01;
    repeat (2) tick();
    chk("sw_hold_ch", 32'(out_ch), 32'd1);
    chk("sw_hold_data", 32'(out_data), 32'd1);
    chk("sw_rr_ptr", 32'(dut.rr_ptr_q), 32'd2);
    out_ready = 1'b1;
    #1 chk("sw_fixed_in_ready", 32'(in_ready), 32'h01);
    tick();
    chk("sw_fixed_out_ch", 32'(out_ch), 32'd0);
    chk("sw_rr_ptr_kept", 32'(dut.rr_ptr_q), 32'd2);

    // Reset while holding a word.
    arb_mode = 2'b10;
    tick();
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    chk("mid_pre_ch", 32'(out_ch), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_ch", 32'(out_ch), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    #1 chk("mid_release_valid", 32'(out_valid), 32'd0);
    tick();
    chk("mid_first_valid", 32'(out_valid), 32'd1);
    chk("mid_first_ch", 32'(out_ch), 32'd0);
    chk("mid_first_data", 32'(out_data), 32'd0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
